// File: rtl/bin2bcd_seq_if.sv
// ============================================================================
// Module  : bin2bcd_seq_if
// Brief   : Request/result bundle between a binary source and bin2bcd_seq.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface bin2bcd_seq_if #(
  parameter int WIDTH  = 9,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;

  modport master (output start, bin_in, input busy, done, bcd_out);
  modport slave  (input start, bin_in, output busy, done, bcd_out);
endinterface

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// Module  : bin2bcd_seq
// Brief   : Sequential double-dabble binary-to-BCD converter, one bit per clock.
//           Optional macro BIN2BCD_LEADING_BLANK_EN blanks leading zero digits.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq #(
  parameter int WIDTH  = 9,
  parameter int DIGITS = 3
) (
  input  wire           clk,
  input  wire           reset,
  bin2bcd_seq_if.slave  bus
);

  localparam int c_BCD_W  = 4 * DIGITS;
  localparam int c_ITER_W = $clog2(WIDTH + 1);
  localparam logic [c_ITER_W-1:0] c_LAST_ITER = c_ITER_W'(WIDTH - 1);

  typedef logic [c_BCD_W-1:0] bcd_t;

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  generate
    if (pow10(DIGITS) <= ((longint'(1) << WIDTH) - 1)) begin : g_bad_digits
      $error("bin2bcd_seq: DIGITS too small to hold 2**WIDTH-1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WIDTH-1:0]      r_bin_sh;
  bcd_t                  r_scratch;
  logic [c_ITER_W-1:0]   r_iter;
  bcd_t                  r_bcd;
  bcd_t                  w_adj;
  bcd_t                  w_shifted;
  bcd_t                  w_result;
  logic                  w_last;

  // Add-3 per digit, no carry between digits
  generate
    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
      logic [3:0] w_dig;
      assign w_dig             = r_scratch[4*d +: 4];
      assign w_adj[4*d +: 4]   = (w_dig >= 4'd5) ? (w_dig + 4'd3) : w_dig;
    end
  endgenerate

  assign w_shifted = bcd_t'({w_adj, r_bin_sh[WIDTH-1]});
  assign w_last    = (r_iter == c_LAST_ITER);

`ifdef BIN2BCD_LEADING_BLANK_EN
  localparam bcd_t c_RST_BCD = bcd_t'({{(DIGITS-1){4'hF}}, 4'h0});

  always_comb begin
    logic w_lead;
    w_result = w_shifted;
    w_lead   = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (w_lead && (w_shifted[4*d +: 4] == 4'd0)) begin
        w_result[4*d +: 4] = 4'hF;
      end else begin
        w_lead = 1'b0;
      end
    end
  end
`else
  localparam bcd_t c_RST_BCD = '0;

  assign w_result = w_shifted;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last)    w_state_nxt = S_DONE;
      S_DONE:                 w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin_sh  <= '0;
      r_scratch <= '0;
      r_iter    <= '0;
      r_bcd     <= c_RST_BCD;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_bin_sh  <= bus.bin_in;
            r_scratch <= '0;
            r_iter    <= '0;
          end
        end
        S_SHIFT: begin
          r_scratch <= w_shifted;
          r_bin_sh  <= r_bin_sh << 1;
          r_iter    <= r_iter + c_ITER_W'(1);
          if (w_last) r_bcd <= w_result;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = (r_state == S_DONE);
  assign bus.bcd_out = r_bcd;

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
// ============================================================================
// Module  : tb_bin2bcd_seq
// Brief   : Directed self-checking bench for bin2bcd_seq.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin2bcd_seq;

`ifdef BIN2BCD_LEADING_BLANK_EN
  localparam logic [11:0] c_EXP_RST  = 12'hFF0;
  localparam logic [11:0] c_EXP_ZERO = 12'hFF0;
  localparam logic [11:0] c_EXP_64   = 12'hF64;
  localparam logic [11:0] c_EXP_15   = 12'hF15;
  localparam logic [11:0] c_EXP_99   = 12'hF99;
`else
  localparam logic [11:0] c_EXP_RST  = 12'h000;
  localparam logic [11:0] c_EXP_ZERO = 12'h000;
  localparam logic [11:0] c_EXP_64   = 12'h064;
  localparam logic [11:0] c_EXP_15   = 12'h015;
  localparam logic [11:0] c_EXP_99   = 12'h099;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  bin2bcd_seq_if #(.WIDTH(9), .DIGITS(3)) bif ();

  bin2bcd_seq #(.WIDTH(9), .DIGITS(3)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One conversion; optional extra start pulse while busy (inj > 0)
  task automatic convert(input logic [8:0] v, input logic [11:0] exp, input int inj);
    logic [11:0] prev;
    int busy_n, done_n, done_at;
    prev       = bif.bcd_out;
    bif.start  = 1'b1;
    bif.bin_in = v;
    @(posedge clk); #1;
    bif.start  = 1'b0;
    bif.bin_in = ~v;
    busy_n = 0; done_n = 0; done_at = -1;
    chk("hold_at_start", 32'(bif.bcd_out), 32'(prev));
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (inj > 0 && k == inj) begin
        bif.start  = 1'b1;
        bif.bin_in = 9'd7;
      end else if (inj > 0 && k == inj + 1) begin
        bif.start  = 1'b0;
      end
      if (bif.busy) busy_n++;
      if (bif.done) begin
        done_n++;
        done_at = k;
      end
    end
    chk("busy_cycles", 32'(busy_n), 32'd10);
    chk("done_count", 32'(done_n), 32'd1);
    chk("done_edge", 32'(done_at), 32'd9);
    chk("result", 32'(bif.bcd_out), 32'(exp));
  endtask

  initial begin
    int done_n, first_at, last_at;
    checks = 0;
    errors = 0;
    reset      = 1'b1;
    bif.start  = 1'b0;
    bif.bin_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bif.busy), 32'd0);
    chk("rst_done", 32'(bif.done), 32'd0);
    chk("rst_bcd", 32'(bif.bcd_out), 32'(c_EXP_RST));
    reset = 1'b0;
    @(posedge clk); #1;

    convert(9'd0,   c_EXP_ZERO, 0);
    convert(9'd511, 12'h511,    0);
    convert(9'd64,  c_EXP_64,   0);
    convert(9'd15,  c_EXP_15,   0);
    convert(9'd99,  c_EXP_99,   0);
    convert(9'd200, 12'h200,    3);

    // Abort at iteration 4 of a 300 conversion
    bif.start  = 1'b1;
    bif.bin_in = 9'd300;
    @(posedge clk); #1;
    bif.start  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy", 32'(bif.busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(bif.busy), 32'd0);
    chk("abort_done", 32'(bif.done), 32'd0);
    chk("abort_bcd", 32'(bif.bcd_out), 32'(c_EXP_RST));

    // Reset and start together: reset wins
    bif.start  = 1'b1;
    bif.bin_in = 9'd123;
    @(posedge clk); #1;
    chk("rst_start_busy", 32'(bif.busy), 32'd0);
    chk("rst_start_done", 32'(bif.done), 32'd0);
    reset = 1'b0;

    // Back-to-back with start held high; k = 0 is the accepting edge
    done_n = 0; first_at = -1; last_at = -1;
    for (int k = 0; k <= 35; k++) begin
      @(posedge clk); #1;
      if (k == 0)  chk("b2b_accept_busy", 32'(bif.busy), 32'd1);
      if (k == 10) chk("b2b_gap_busy", 32'(bif.busy), 32'd0);
      if (k == 8)  chk("b2b_pre_done_bcd", 32'(bif.bcd_out), 32'(c_EXP_RST));
      if (bif.done) begin
        done_n++;
        if (first_at < 0) first_at = k;
        last_at = k;
        chk("b2b_result", 32'(bif.bcd_out), 32'h123);
      end
    end
    bif.start = 1'b0;
    chk("b2b_done_count", 32'(done_n), 32'd3);
    chk("b2b_first_done", 32'(first_at), 32'd9);
    chk("b2b_last_done", 32'(last_at), 32'd31);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential double-dabble binary-to-BCD converter placed downstream of the integer square-root datapath. It converts the 9-bit switch operand, or the zero-extended 4-bit root `count`, into packed BCD for the display stage. The block performs one add-3/shift iteration per clock and signals completion with a one-cycle `done` pulse. The result is held until the next conversion completes.

## Interface
- `WIDTH`, default 9, binary input width.
- `DIGITS`, default 3, number of BCD output digits.
  - Must satisfy 10^DIGITS > 2^WIDTH − 1.
  - This is checked at elaboration.
- `clk`, input, 1, single clock, rising-edge.
- `reset`, input, 1, asynchronous, active-high.
- `start`, input, 1, conversion request, sampled only in IDLE.
- `bin_in`, input, WIDTH, binary value, captured on the accepting edge.
- `busy`, output, 1, high in SHIFT and DONE.
- `done`, output, 1, one-cycle completion pulse.
- `bcd_out`, output, 4*DIGITS, packed BCD with digit 0 in bits [3:0].

## Operation
- Internal state:
  - `bin_sh`: WIDTH-bit shift register.
  - `scratch`: 4*DIGITS-bit BCD accumulator.
  - `iter`: iteration counter, width ceil(log2(WIDTH+1)).
- **IDLE**
  - `start` = 1: `bin_sh` ← `bin_in`, `scratch` ← 0, `iter` ← 0, go to SHIFT.
  - `start` = 0: stay in IDLE.
- **SHIFT**, on each edge:
  - Every `scratch` digit ≥ 5 gets +3; carries are confined to that digit.
  - Then {`scratch`, `bin_sh`} is shifted left by 1.
  - `iter` ← `iter` + 1.
  - On the edge where `iter` = WIDTH−1 (the last iteration):
    - `bcd_out` ← the post-shift `scratch`.
    - `done` ← 1.
    - Go to DONE.
- **DONE**: one cycle only. `done` ← 0, go to IDLE.
- `start` is ignored in SHIFT and DONE. No queueing; the request is lost.
- `bin_in` changes after the accepting edge have no effect.
- `bcd_out` is not cleared at start. It changes only on the completion edge or on reset.
- Every BCD digit of `bcd_out` is always within 0–9, except blank codes (see Configuration).

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE.
  - `busy` = 0, `done` = 0.
  - `iter` = 0, `bin_sh` = 0, `scratch` = 0.
  - `bcd_out` = all zero (see Configuration for the blanking variant).
- Let t0 be the edge that accepts `start`.
  - Iterations occur on edges t1..tWIDTH.
  - `busy` is high from t0 until t(WIDTH+1).
  - `done` and the new `bcd_out` are valid after edge tWIDTH (t9 for the default).
  - `done` clears at t(WIDTH+1).
- Throughput:
  - With `start` held high, a new conversion is accepted at t(WIDTH+2).
  - One conversion per WIDTH+2 cycles (11 for the default).
- Reset mid-operation:
  - Aborts immediately; all state returns to reset values.
  - The partial result is discarded and `done` does not pulse.
- Simultaneous `reset` and `start`: reset wins and `start` is ignored.
- Boundary values:
  - `bin_in` = 0 yields all-zero digits.
  - `bin_in` = 2^WIDTH−1 yields exact decimal with no overflow (guaranteed by the DIGITS check).

## Configuration
- Macro: `BIN2BCD_LEADING_BLANK_EN`.
- Defined:
  - On the completion write, every leading zero digit above digit 0 is replaced with 4'hF (display blank code).
  - Digit 0 is always numeric.
  - Reset value of `bcd_out` is (DIGITS−1) blank digits followed by 0 (12'hFF0 for the default).
  - Timing is unchanged.
- Undefined:
  - Leading zeros are emitted as 4'h0.
  - Reset value is all zero.

## Test plan
- **Zero input.** Reset, then `start` with `bin_in` = 0.
  - `done` pulses exactly once, 9 edges after acceptance.
  - `bcd_out` = 12'h000 (12'hFF0 with the macro).
- **Maximum input.** `bin_in` = 9'd511.
  - `bcd_out` = 12'h511.
  - `busy` is high for exactly 10 cycles.
- **Root-range input.** `bin_in` = 9'd64.
  - `bcd_out` = 12'h064 (12'hF64 with the macro).
- **Zero-extended root.** `bin_in` = 9'd15.
  - `bcd_out` = 12'h015 (12'hF15 with the macro).
- **Start while busy.** Convert 9'd200; at iteration 3, pulse `start` with `bin_in` = 9'd7.
  - The request is ignored: `bcd_out` = 12'h200, with a single `done`.
- **Reset mid-run, then back-to-back.**
  - Assert `reset` at iteration 4 of converting 9'd300: outputs return to reset values immediately and no `done` appears.
  - Then hold `start` high with 9'd123: `done` pulses every 11 cycles and `bcd_out` = 12'h123.
